// File: rtl/rv_pkg.sv
// Shared register-file constants and the write-back record carried to the rf port.
package rv_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
    logic                  src_long;
  } wb_rec_t;
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr_q, rptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset; the pointers decide what is valid.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = mem_q[rptr_q[AW-1:0]];
  assign o_empty = (wptr_q == rptr_q);
  assign o_full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
endmodule

// File: rtl/rf_writeback.sv
// Merges ALU and long-unit results onto the single rf write port and tracks
// outstanding long-latency destinations for decode RAW stalls.
module rf_writeback
  import rv_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_alu_valid,
  input  logic [REG_ADDR_W-1:0] i_alu_rd,
  input  logic [XLEN-1:0]       i_alu_data,
  input  logic                  i_lu_valid,
  output logic                  o_lu_ready,
  input  logic [REG_ADDR_W-1:0] i_lu_rd,
  input  logic [XLEN-1:0]       i_lu_data,
  input  logic                  i_issue_valid,
  input  logic [REG_ADDR_W-1:0] i_issue_rd,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  output logic                  o_rs1_busy,
  output logic                  o_rs2_busy,
  output logic                  o_rd_wen,
  output logic [REG_ADDR_W-1:0] o_rd_waddr,
  output logic [XLEN-1:0]       o_rd_wdata,
  output logic                  o_idle
);
  localparam int FW = REG_ADDR_W + XLEN;

  logic          fifo_full, fifo_empty, fifo_pop, lu_push;
  logic [FW-1:0] fifo_head;
  wb_rec_t       out_q, out_d;
  logic          wen_q, wen_d;
  logic [31:0]   busy_q, busy_d;
  logic          commit_long;

  assign o_lu_ready = !fifo_full && !i_rst;
  assign lu_push    = i_lu_valid && o_lu_ready;

  wb_fifo #(.DEPTH(FIFO_DEPTH), .W(FW)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (lu_push),
    .i_wdata ({i_lu_rd, i_lu_data}),
    .i_pop   (fifo_pop),
    .o_rdata (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // ALU always wins the port; the FIFO head drains only on ALU-idle cycles.
  always_comb begin
    out_d    = '0;
    fifo_pop = 1'b0;
    if (i_alu_valid) begin
      out_d = '{rd: i_alu_rd, data: i_alu_data, src_long: 1'b0};
    end else if (!fifo_empty) begin
      out_d    = '{rd: fifo_head[FW-1:XLEN], data: fifo_head[XLEN-1:0], src_long: 1'b1};
      fifo_pop = 1'b1;
    end
    wen_d = (i_alu_valid || !fifo_empty) && (out_d.rd != REG_X0);
  end

  assign commit_long = wen_q && out_q.src_long;

  // Clear first so a same-edge issue to the committing address keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (commit_long) busy_d[out_q.rd] = 1'b0;
    if (i_issue_valid && i_issue_rd != REG_X0) busy_d[i_issue_rd] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_q  <= '0;
      wen_q  <= 1'b0;
      busy_q <= '0;
    end else begin
      out_q  <= out_d;
      wen_q  <= wen_d;
      busy_q <= busy_d;
    end
  end

  assign o_rd_wen   = wen_q;
  assign o_rd_waddr = out_q.rd;
  assign o_rd_wdata = out_q.data;

  assign o_rs1_busy = (i_rs1_addr != REG_X0) &&
                      (busy_q[i_rs1_addr] || (commit_long && out_q.rd == i_rs1_addr));
  assign o_rs2_busy = (i_rs2_addr != REG_X0) &&
                      (busy_q[i_rs2_addr] || (commit_long && out_q.rd == i_rs2_addr));

  assign o_idle = fifo_empty && (busy_q == '0) && !wen_q;
endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback: inputs change on the falling edge, outputs are checked there too.
module tb_rf_writeback;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lu_valid, issue_valid;
  logic [4:0]  alu_rd, lu_rd, issue_rd, rs1, rs2;
  logic [31:0] alu_data, lu_data;
  logic        lu_ready, rs1_busy, rs2_busy, rd_wen, idle;
  logic [4:0]  rd_waddr;
  logic [31:0] rd_wdata;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_writeback #(.FIFO_DEPTH(2)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_alu_valid(alu_valid), .i_alu_rd(alu_rd), .i_alu_data(alu_data),
    .i_lu_valid(lu_valid), .o_lu_ready(lu_ready), .i_lu_rd(lu_rd), .i_lu_data(lu_data),
    .i_issue_valid(issue_valid), .i_issue_rd(issue_rd),
    .i_rs1_addr(rs1), .i_rs2_addr(rs2),
    .o_rs1_busy(rs1_busy), .o_rs2_busy(rs2_busy),
    .o_rd_wen(rd_wen), .o_rd_waddr(rd_waddr), .o_rd_wdata(rd_wdata),
    .o_idle(idle)
  );

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".wen"}, 32'(rd_wen), 32'd1);
    chk({tag, ".addr"}, 32'(rd_waddr), 32'(a));
    chk({tag, ".data"}, rd_wdata, d);
  endtask

  initial begin
    rst = 1'b1; alu_valid = 0; lu_valid = 0; issue_valid = 0;
    alu_rd = 0; lu_rd = 0; issue_rd = 0; rs1 = 0; rs2 = 0; alu_data = 0; lu_data = 0;
    cyc();
    chk("rst.ready", 32'(lu_ready), 0);
    chk("rst.wen", 32'(rd_wen), 0);
    chk("rst.addr", 32'(rd_waddr), 0);
    chk("rst.data", rd_wdata, 0);
    rst = 1'b0;
    cyc();
    chk("post_rst.ready", 32'(lu_ready), 1);
    chk("post_rst.idle", 32'(idle), 1);

    // ALU write to x5, then to x0
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
    cyc();
    chk_wr("alu_x5", 5, 32'h1234);
    alu_valid = 0;
    cyc();
    chk("alu_x5.one_cycle", 32'(rd_wen), 0);
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFF;
    cyc();
    chk("alu_x0.wen", 32'(rd_wen), 0);
    alu_valid = 0;
    cyc();
    chk("alu_x0.idle", 32'(idle), 1);

    // Issue x7, long result 0xDEAD
    rs1 = 7; issue_valid = 1; issue_rd = 7;
    cyc();
    issue_valid = 0; #1;
    chk("x7.busy_after_issue", 32'(rs1_busy), 1);
    lu_valid = 1; lu_rd = 7; lu_data = 32'hDEAD;
    chk("x7.ready", 32'(lu_ready), 1);
    cyc();
    lu_valid = 0;
    chk("x7.no_bypass", 32'(rd_wen), 0);
    chk("x7.busy_buffered", 32'(rs1_busy), 1);
    cyc();
    chk_wr("x7.port", 7, 32'hDEAD);
    chk("x7.busy_port", 32'(rs1_busy), 1);
    cyc();
    chk("x7.after_wen", 32'(rd_wen), 0);
    chk("x7.busy_cleared", 32'(rs1_busy), 0);
    chk("x7.idle", 32'(idle), 1);

    // ALU for 4 cycles while the long unit offers x3, x4, x6
    alu_valid = 1; alu_rd = 10; alu_data = 32'hA0;
    lu_valid = 1; lu_rd = 3; lu_data = 32'h33;
    chk("burst.ready0", 32'(lu_ready), 1);
    cyc();
    chk_wr("burst.alu10", 10, 32'hA0);
    alu_rd = 11; alu_data = 32'hA1; lu_rd = 4; lu_data = 32'h44;
    chk("burst.ready1", 32'(lu_ready), 1);
    cyc();
    chk_wr("burst.alu11", 11, 32'hA1);
    alu_rd = 12; alu_data = 32'hA2; lu_rd = 6; lu_data = 32'h66;
    chk("burst.ready_full_a", 32'(lu_ready), 0);
    cyc();
    chk_wr("burst.alu12", 12, 32'hA2);
    alu_rd = 13; alu_data = 32'hA3;
    chk("burst.ready_full_b", 32'(lu_ready), 0);
    cyc();
    chk_wr("burst.alu13", 13, 32'hA3);
    alu_valid = 0;
    chk("burst.ready_full_c", 32'(lu_ready), 0);
    cyc();
    chk_wr("burst.x3", 3, 32'h33);
    chk("burst.ready_freed", 32'(lu_ready), 1);
    cyc();
    lu_valid = 0;
    chk_wr("burst.x4", 4, 32'h44);
    cyc();
    chk_wr("burst.x6", 6, 32'h66);
    cyc();
    chk("burst.drained", 32'(rd_wen), 0);
    chk("burst.idle", 32'(idle), 1);

    // Re-issue to x9 on the edge its earlier long write commits
    rs2 = 9; issue_valid = 1; issue_rd = 9;
    cyc();
    issue_valid = 0; lu_valid = 1; lu_rd = 9; lu_data = 32'h99;
    cyc();
    lu_valid = 0;
    cyc();
    chk_wr("x9.port", 9, 32'h99);
    issue_valid = 1; issue_rd = 9;
    cyc();
    issue_valid = 0; #1;
    chk("x9.set_wins", 32'(rs2_busy), 1);
    lu_valid = 1; lu_data = 32'h999;
    cyc();
    lu_valid = 0;
    cyc();
    chk_wr("x9.second", 9, 32'h999);
    cyc();
    chk("x9.cleared", 32'(rs2_busy), 0);

    // Fill FIFO behind ALU x0 traffic, then reset
    alu_valid = 1; alu_rd = 0; lu_valid = 1; lu_rd = 20; lu_data = 32'h20;
    cyc();
    lu_rd = 21; lu_data = 32'h21;
    cyc();
    chk("fill.ready_full", 32'(lu_ready), 0);
    chk("fill.idle", 32'(idle), 0);
    alu_valid = 0; lu_valid = 0; rst = 1;
    cyc();
    chk("fill.ready_in_rst", 32'(lu_ready), 0);
    rst = 0;
    cyc();
    chk("fill.wen0", 32'(rd_wen), 0);
    chk("fill.idle_after", 32'(idle), 1);
    chk("fill.ready_after", 32'(lu_ready), 1);
    cyc();
    chk("fill.wen1", 32'(rd_wen), 0);

    // Long result to x0
    rs1 = 0; lu_valid = 1; lu_rd = 0; lu_data = 32'h55;
    issue_valid = 1; issue_rd = 0;
    chk("x0.ready", 32'(lu_ready), 1);
    cyc();
    lu_valid = 0; issue_valid = 0;
    chk("x0.busy_a", 32'(rs1_busy), 0);
    chk("x0.idle_buffered", 32'(idle), 0);
    cyc();
    chk("x0.wen", 32'(rd_wen), 0);
    chk("x0.busy_b", 32'(rs1_busy), 0);
    chk("x0.idle_popped", 32'(idle), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
